cam_mac_bank: RTL and testbench

Synthesizable responder for the CELLA bank command interface: a 4-row × 8-bit storage bank answering the same pin set the bank stimulus drives (`CS`, `MAC_en`, `w_en`, `read_bar`, `addr`, `word`, `query`). In MAC mode it performs row writes and single-cycle-latency Q/QB reads. In CAM mode it runs a 2-stage nibble-match search pipeline with priority encoding and a hit count. It replaces the bank behavioural model at the far end of the interface and sits directly under the bank-level testbench and the array top.

---
 rtl/cam_mac_bank.sv | 125 ++++++++++++
 tb/tb_cam_mac_bank.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cam_mac_bank.sv
// cam_mac_bank: 4-row x 8-bit storage bank answering MAC-mode row reads/writes
// and a 2-stage CAM nibble search with priority encoding and hit count.
module cam_mac_bank (
  input  logic       clk,
  input  logic       rst,
  input  logic       CS,
  input  logic       MAC_en,
  input  logic       w_en,
  input  logic       read_bar,
  input  logic [1:0] addr,
  input  logic [7:0] word,
  input  logic [3:0] query,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic [7:0] match,
  output logic       match_valid,
  output logic       hit,
  output logic [2:0] hit_idx,
  output logic [3:0] hit_cnt
);

  logic [7:0] mem_q [4];
  logic [3:0] rowVld_q;

  logic [7:0] rdata_q;
  logic [7:0] rdata_d;
  logic       rdataValid_q;

  logic [7:0] m1_q;
  logic [7:0] m1_d;
  logic       s1Valid_q;

  logic [7:0] match_q;
  logic       matchValid_q;
  logic       hit_q;
  logic [2:0] hitIdx_q;
  logic [2:0] hitIdx_d;
  logic [3:0] hitCnt_q;
  logic [3:0] hitCnt_d;

  logic isWrite;
  logic isRead;
  logic isSearch;

  assign isWrite  = CS & MAC_en & w_en;
  assign isRead   = CS & MAC_en & ~w_en;
  assign isSearch = CS & ~MAC_en;

  assign rdata_d = read_bar ? ~mem_q[addr] : mem_q[addr];

  // Stage-1 compare: each row contributes a low-nibble and a high-nibble bit,
  // gated by whether the row has ever been written.
  always_comb begin
    m1_d = '0;
    for (int r = 0; r < 4; r++) begin
      m1_d[2*r]   = rowVld_q[r] & (mem_q[r][3:0] == query);
      m1_d[2*r+1] = rowVld_q[r] & (mem_q[r][7:4] == query);
    end
  end

  // Stage-2 reductions: lowest set index wins, so scan from the top down.
  always_comb begin
    hitIdx_d = '0;
    hitCnt_d = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m1_q[i]) begin
        hitIdx_d = 3'(i);
      end
    end
    for (int i = 0; i < 8; i++) begin
      hitCnt_d = hitCnt_d + {3'b000, m1_q[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 4; r++) begin
        mem_q[r] <= '0;
      end
      rowVld_q     <= '0;
      rdata_q      <= '0;
      rdataValid_q <= 1'b0;
      m1_q         <= '0;
      s1Valid_q    <= 1'b0;
      match_q      <= '0;
      matchValid_q <= 1'b0;
      hit_q        <= 1'b0;
      hitIdx_q     <= '0;
      hitCnt_q     <= '0;
    end else begin
      if (isWrite) begin
        mem_q[addr]    <= word;
        rowVld_q[addr] <= 1'b1;
      end

      rdataValid_q <= isRead;
      if (isRead) begin
        rdata_q <= rdata_d;
      end

      // Pipeline is never flushed on mode change; in-flight searches drain.
      s1Valid_q <= isSearch;
      if (isSearch) begin
        m1_q <= m1_d;
      end

      matchValid_q <= s1Valid_q;
      if (s1Valid_q) begin
        match_q  <= m1_q;
        hit_q    <= |m1_q;
        hitIdx_q <= hitIdx_d;
        hitCnt_q <= hitCnt_d;
      end
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdataValid_q;
  assign match       = match_q;
  assign match_valid = matchValid_q;
  assign hit         = hit_q;
  assign hit_idx     = hitIdx_q;
  assign hit_cnt     = hitCnt_q;

endmodule

// File: tb/tb_cam_mac_bank.sv
// tb_cam_mac_bank: directed vector table for the bank command set, then
// randomized traffic compared against a queue-based reference model.
module tb_cam_mac_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       CS;
  logic       MAC_en;
  logic       w_en;
  logic       read_bar;
  logic [1:0] addr;
  logic [7:0] word;
  logic [3:0] query;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic [7:0] match;
  logic       match_valid;
  logic       hit;
  logic [2:0] hit_idx;
  logic [3:0] hit_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic       cs;
    logic       mac;
    logic       wen;
    logic       rb;
    logic [1:0] addr;
    logic [7:0] word;
    logic [3:0] query;
    logic       rv;
    logic [7:0] rd;
    logic       mv;
    logic [7:0] m;
    logic       hit;
    logic [2:0] idx;
    logic [3:0] cnt;
  } vec_t;

  typedef struct {
    int         due;
    logic [7:0] m;
  } pend_t;

  vec_t vecs[$];

  logic [7:0] modelMem [4];
  logic [3:0] modelVld;
  pend_t      pendQ[$];
  int         cycleNo = 0;
  logic       eRv;
  logic [7:0] eRd;
  logic       eMv;
  logic [7:0] eM;
  logic       eHit;
  logic [2:0] eIdx;
  logic [3:0] eCnt;

  cam_mac_bank dut (
    .clk         (clk),
    .rst         (rst),
    .CS          (CS),
    .MAC_en      (MAC_en),
    .w_en        (w_en),
    .read_bar    (read_bar),
    .addr        (addr),
    .word        (word),
    .query       (query),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .match       (match),
    .match_valid (match_valid),
    .hit         (hit),
    .hit_idx     (hit_idx),
    .hit_cnt     (hit_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkVec(
    input logic r, cs, mac, wen, rb, input logic [1:0] a, input logic [7:0] w,
    input logic [3:0] q, input logic rv, input logic [7:0] rd, input logic mv,
    input logic [7:0] m, input logic h, input logic [2:0] idx, input logic [3:0] cnt);
    vec_t v;
    v.rst = r; v.cs = cs; v.mac = mac; v.wen = wen; v.rb = rb;
    v.addr = a; v.word = w; v.query = q;
    v.rv = rv; v.rd = rd; v.mv = mv; v.m = m; v.hit = h; v.idx = idx; v.cnt = cnt;
    return v;
  endfunction

  // Reference model: rows as an array, searches as a queue of results due later.
  task automatic modelEdge(input vec_t v);
    pend_t      p;
    logic [7:0] m;
    cycleNo++;
    if (v.rst) begin
      for (int r = 0; r < 4; r++) modelMem[r] = 8'h00;
      modelVld = 4'h0;
      pendQ.delete();
      eRv = 0; eRd = 0; eMv = 0; eM = 0; eHit = 0; eIdx = 0; eCnt = 0;
      return;
    end
    eRv = 0;
    eMv = 0;
    if (pendQ.size() > 0 && pendQ[0].due == cycleNo) begin
      p = pendQ.pop_front();
      eMv = 1;
      eM = p.m;
      eHit = (p.m != 0);
      eCnt = 4'($countones(p.m));
      eIdx = 0;
      for (int i = 0; i < 8; i++) begin
        if (p.m[i]) begin
          eIdx = 3'(i);
          break;
        end
      end
    end
    if (v.cs && !v.mac) begin
      m = 0;
      for (int r = 0; r < 4; r++) begin
        if (modelVld[r] && modelMem[r][3:0] == v.query) m[2*r] = 1;
        if (modelVld[r] && modelMem[r][7:4] == v.query) m[2*r+1] = 1;
      end
      p.due = cycleNo + 1;
      p.m = m;
      pendQ.push_back(p);
    end
    if (v.cs && v.mac && !v.wen) begin
      eRv = 1;
      eRd = v.rb ? ~modelMem[v.addr] : modelMem[v.addr];
    end
    if (v.cs && v.mac && v.wen) begin
      modelMem[v.addr] = v.word;
      modelVld[v.addr] = 1;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = v.rst; CS = v.cs; MAC_en = v.mac; w_en = v.wen; read_bar = v.rb;
    addr = v.addr; word = v.word; query = v.query;
    modelEdge(v);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cycleNo, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic rv, input logic [7:0] rd,
                          input logic mv, input logic [7:0] m, input logic h,
                          input logic [2:0] idx, input logic [3:0] cnt);
    checkOutput({tag, ".rdata_valid"}, {7'b0, rdata_valid}, {7'b0, rv});
    checkOutput({tag, ".rdata"}, rdata, rd);
    checkOutput({tag, ".match_valid"}, {7'b0, match_valid}, {7'b0, mv});
    checkOutput({tag, ".match"}, match, m);
    checkOutput({tag, ".hit"}, {7'b0, hit}, {7'b0, h});
    checkOutput({tag, ".hit_idx"}, {5'b0, hit_idx}, {5'b0, idx});
    checkOutput({tag, ".hit_cnt"}, {4'b0, hit_cnt}, {4'b0, cnt});
  endtask

  initial begin
    vec_t v;
    rst = 1; CS = 0; MAC_en = 0; w_en = 0; read_bar = 0; addr = 0; word = 0; query = 0;

    //                r  cs mac wen rb addr word   q     rv rd    mv m      h idx cnt
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 8'h00, 4'h0, 0, 8'h00, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 1, 1, 0, 0, 8'hAA, 4'h0, 0, 8'h00, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 1, 1, 0, 1, 8'h55, 4'h0, 0, 8'h00, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 1, 0, 0, 0, 8'h00, 4'h0, 1, 8'hAA, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 1, 0, 1, 0, 8'h00, 4'h0, 1, 8'h55, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 0, 0, 0, 0, 8'h00, 4'hA, 0, 8'h55, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 0, 0, 0, 0, 8'h00, 4'hF, 0, 8'h55, 1, 8'h03, 1, 0, 2));
    vecs.push_back(mkVec(0, 1, 0, 0, 0, 0, 8'h00, 4'h5, 0, 8'h55, 1, 8'h00, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 0, 0, 0, 0, 8'h00, 4'h0, 0, 8'h55, 1, 8'h0C, 1, 2, 2));
    vecs.push_back(mkVec(0, 1, 1, 1, 0, 2, 8'h33, 4'h0, 0, 8'h55, 1, 8'h00, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 1, 0, 0, 2, 8'h00, 4'h0, 1, 8'h33, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 0, 0, 0, 0, 8'h00, 4'hA, 0, 8'h33, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mkVec(1, 1, 0, 0, 0, 0, 8'h00, 4'hA, 0, 8'h00, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 1, 0, 0, 0, 8'h00, 4'h0, 1, 8'h00, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 0, 0, 0, 0, 8'h00, 4'hA, 0, 8'h00, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 8'h00, 4'h0, 0, 8'h00, 1, 8'h00, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 1, 1, 0, 3, 8'hFF, 4'h0, 0, 8'h00, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 1, 0, 0, 3, 8'h00, 4'h0, 0, 8'h00, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 1, 0, 0, 3, 8'h00, 4'h0, 1, 8'h00, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 1, 0, 1, 3, 8'h00, 4'h0, 1, 8'hFF, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 1, 1, 0, 3, 8'h3C, 4'h0, 0, 8'hFF, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 0, 0, 0, 0, 8'h00, 4'h3, 0, 8'hFF, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 0, 0, 0, 0, 8'h00, 4'hC, 0, 8'hFF, 1, 8'h80, 1, 7, 1));
    vecs.push_back(mkVec(0, 1, 0, 0, 0, 0, 8'h00, 4'h0, 0, 8'hFF, 1, 8'h40, 1, 6, 1));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 8'h00, 4'h0, 0, 8'hFF, 1, 8'h00, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 8'h00, 4'h0, 0, 8'hFF, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 1, 1, 0, 0, 8'h77, 4'h0, 0, 8'hFF, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 1, 1, 0, 1, 8'h77, 4'h0, 0, 8'hFF, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 1, 1, 0, 2, 8'h77, 4'h0, 0, 8'hFF, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 1, 1, 0, 3, 8'h77, 4'h0, 0, 8'hFF, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 0, 0, 0, 0, 8'h00, 4'h7, 0, 8'hFF, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 8'h00, 4'h0, 0, 8'hFF, 1, 8'hFF, 1, 0, 8));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 8'h00, 4'h0, 0, 8'hFF, 0, 8'hFF, 1, 0, 8));

    $display("[TB] directed table: %0d vectors", vecs.size());
    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k]);
      checkAll($sformatf("vec%0d", k), vecs[k].rv, vecs[k].rd, vecs[k].mv,
               vecs[k].m, vecs[k].hit, vecs[k].idx, vecs[k].cnt);
    end

    $display("[TB] randomized traffic against reference model");
    v = mkVec(1, 0, 0, 0, 0, 0, 8'h00, 4'h0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    applyStimulus(v);
    checkAll("rndReset", eRv, eRd, eMv, eM, eHit, eIdx, eCnt);
    for (int k = 0; k < 3000; k++) begin
      v.rst   = ($urandom_range(0, 99) == 0);
      v.cs    = ($urandom_range(0, 7) != 0);
      v.mac   = $urandom_range(0, 1);
      v.wen   = $urandom_range(0, 1);
      v.rb    = $urandom_range(0, 1);
      v.addr  = 2'($urandom_range(0, 3));
      v.word  = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      v.query = 4'($urandom_range(0, 3));
      applyStimulus(v);
      checkAll($sformatf("rnd%0d", k), eRv, eRd, eMv, eM, eHit, eIdx, eCnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
